// File: rtl/cd_tx_frame_ctrl.sv
// cd_tx_frame_ctrl: sequences one frame from the double-buffered tx RAM to the byte serializer.
// Optional CRC-16/MODBUS trailer is built in when CD_TX_CRC_EN is defined.
module cd_tx_frame_ctrl #(
    parameter int unsigned MAX_LEN = 253
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       unread,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_byte,
    output logic       rd_done,
    input  logic       tx_permit,
    input  logic       abort,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
);

    localparam int unsigned BW = 8;
    localparam int unsigned CW = 16;
    localparam logic [BW-1:0] MAX_LEN_B = BW'(MAX_LEN);

`ifdef CD_TX_CRC_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, CRC_L, CRC_H, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic [BW-1:0] idx_q, idx_d;
    logic [BW-1:0] len_q, len_d;
    logic [BW-1:0] tx_byte_d, rd_addr_d;
    logic          tx_valid_d, rd_en_d, rd_done_d, frame_start_d, frame_end_d, busy_d;
    logic          hs_c, last_c;

`ifdef CD_TX_CRC_EN
    logic [CW-1:0] crc_q, crc_d, crc_upd_c;

    // One reflected CRC-16/MODBUS byte update (poly 0xA001).
    function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] c, input logic [BW-1:0] b);
        logic [CW-1:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_upd_c = crc_step(crc_q, tx_byte);
`endif

    assign hs_c   = tx_valid & tx_ready;
    // Last byte only once len is latched (idx>=2); idx tops out at 255, so no wrap.
    assign last_c = (idx_q >= 8'd2) && ({1'b0, idx_q} == ({1'b0, len_q} + 9'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            tx_byte     <= '0;
            tx_valid    <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_done     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
`ifdef CD_TX_CRC_EN
            crc_q       <= 16'hFFFF;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            tx_byte     <= tx_byte_d;
            tx_valid    <= tx_valid_d;
            rd_en       <= rd_en_d;
            rd_addr     <= rd_addr_d;
            rd_done     <= rd_done_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            busy        <= busy_d;
`ifdef CD_TX_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        tx_byte_d     = tx_byte;
        tx_valid_d    = tx_valid;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr;
        rd_done_d     = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
`ifdef CD_TX_CRC_EN
        crc_d         = crc_q;
`endif
        // Abort cancels everything in flight without releasing the buffer.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            idx_d      = '0;
            tx_valid_d = 1'b0;
`ifdef CD_TX_CRC_EN
            crc_d      = 16'hFFFF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef CD_TX_CRC_EN
                    crc_d = 16'hFFFF;
`endif
                    if (unread && tx_permit) begin
                        state_d   = FETCH;
                        idx_d     = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    tx_byte_d     = rd_byte;
                    tx_valid_d    = 1'b1;
                    frame_start_d = (idx_q == 8'd0);
                    if (idx_q == 8'd2) begin
                        len_d = (rd_byte > MAX_LEN_B) ? MAX_LEN_B : rd_byte;
                    end
                    state_d = SEND;
                end
                SEND: begin
                    if (hs_c) begin
                        tx_valid_d = 1'b0;
`ifdef CD_TX_CRC_EN
                        crc_d = crc_upd_c;
`endif
                        if (last_c) begin
`ifdef CD_TX_CRC_EN
                            state_d    = CRC_L;
                            tx_byte_d  = crc_upd_c[7:0];
                            tx_valid_d = 1'b1;
`else
                            state_d     = DONE;
                            rd_done_d   = 1'b1;
                            frame_end_d = 1'b1;
`endif
                        end else begin
                            idx_d     = idx_q + 8'd1;
                            rd_en_d   = 1'b1;
                            rd_addr_d = idx_q + 8'd1;
                            state_d   = FETCH;
                        end
                    end
                end
`ifdef CD_TX_CRC_EN
                CRC_L: begin
                    if (hs_c) begin
                        tx_byte_d = crc_q[15:8];
                        state_d   = CRC_H;
                    end
                end
                CRC_H: begin
                    if (hs_c) begin
                        tx_valid_d  = 1'b0;
                        rd_done_d   = 1'b1;
                        frame_end_d = 1'b1;
                        state_d     = DONE;
                    end
                end
`endif
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_cd_tx_frame_ctrl.sv
// Testbench for cd_tx_frame_ctrl: table vectors, randomized frames against a byte-list model,
// and hand sequences for hold, grant, abort, reset and back-to-back buffers.
`timescale 1ns/1ps
module tb_cd_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       unread;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_byte = 8'h00;
    logic       rd_done;
    logic       tx_permit;
    logic       abort;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

`ifdef CD_TX_CRC_EN
    localparam int CRC_BYTES = 2;
`else
    localparam int CRC_BYTES = 0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [2][256];
    int n_loaded = 0;
    int n_released = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int starts = 0, ends = 0, dones = 0, rd_en_cnt = 0, fetch_idx = 0;
    bit prev_pending = 0, prev_abort = 0, idle_since_done = 1, gap_idle = 0;
    logic [7:0] prev_byte = 8'h00;
    int ready_pct = 100;
    int hold_ready = 0;

    cd_tx_frame_ctrl #(.MAX_LEN(253)) dut (
        .clk(clk), .reset_n(reset_n), .unread(unread), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_byte(rd_byte), .rd_done(rd_done), .tx_permit(tx_permit), .abort(abort),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );

    always #5 clk = ~clk;

    assign unread = (n_loaded != n_released);

    // Double-buffered frame RAM: 1-cycle read latency, rd_done switches buffer.
    always @(posedge clk) begin
        if (rd_en) rd_byte <= ram[n_released % 2][rd_addr];
        if (rd_done) n_released <= n_released + 1;
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = (hold_ready == 0) && (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: handshake capture, hold stability, sequential read addresses.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_pending = 0;
            prev_abort = 0;
            fetch_idx = 0;
        end else begin
            if (prev_pending && !prev_abort) begin
                chk("hold_valid", int'(tx_valid), 1);
                chk("hold_byte", int'(tx_byte), int'(prev_byte));
            end
            if (rd_en) begin
                chk("rd_addr_seq", int'(rd_addr), fetch_idx);
                fetch_idx++;
                rd_en_cnt++;
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_byte);
            if (frame_start) starts++;
            if (frame_end) ends++;
            if (!busy) idle_since_done = 1;
            if (rd_done) begin
                dones++;
                gap_idle = idle_since_done;
                idle_since_done = 0;
                fetch_idx = 0;
            end
            if (abort) fetch_idx = 0;
            prev_pending = tx_valid && !tx_ready;
            prev_byte = tx_byte;
            prev_abort = abort;
        end
    end

`ifdef CD_TX_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: frame is the first 3+min(len,253) RAM bytes of the buffer, then the CRC if built in.
    task automatic load_frame(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        int b;
        int cnt;
`ifdef CD_TX_CRC_EN
        logic [15:0] c;
        c = 16'hFFFF;
`endif
        b = n_loaded % 2;
        ram[b][0] = src;
        ram[b][1] = dst;
        ram[b][2] = len;
        for (int i = 3; i < 256; i++) ram[b][i] = 8'($urandom);
        cnt = 3 + ((int'(len) > 253) ? 253 : int'(len));
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(ram[b][i]);
`ifdef CD_TX_CRC_EN
            c = crc_ref(c, ram[b][i]);
`endif
        end
`ifdef CD_TX_CRC_EN
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
`endif
        n_loaded++;
    endtask

    task automatic wait_released(input int target, input int budget, input string name);
        int n = 0;
        while (n_released < target && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, int'(n_released >= target), 1);
    endtask

    task automatic wait_got(input int cnt, input int budget, input string name);
        int n = 0;
        while (got_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_got_timeout"}, int'(got_q.size() >= cnt), 1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!tx_valid && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_valid_timeout"}, int'(tx_valid), 1);
    endtask

    task automatic compare_frames(input string name);
        int bad = 0;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        chk({name, "_bytes"}, bad, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_counts();
        starts = 0;
        ends = 0;
        dones = 0;
        got_q.delete();
    endtask

    typedef struct {
        int rd_en, rd_addr, tx_valid, tx_byte, fstart, fend, rd_done, busy;
    } cyc_t;

    typedef struct {
        logic [7:0] src, dst, len;
        int ready_pct;
        int exp_bytes;
    } vec_t;

    cyc_t cyc[13];
    vec_t vecs[7];
    int   ncyc;

    initial begin
        // Cycle-exact trace of the minimum frame 01 02 00 with the serializer always ready.
        cyc[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 1};
        cyc[1]  = '{0, 0, 0, 8'h00, 0, 0, 0, 1};
        cyc[2]  = '{0, 0, 1, 8'h01, 1, 0, 0, 1};
        cyc[3]  = '{1, 1, 0, 8'h01, 0, 0, 0, 1};
        cyc[4]  = '{0, 1, 0, 8'h01, 0, 0, 0, 1};
        cyc[5]  = '{0, 1, 1, 8'h02, 0, 0, 0, 1};
        cyc[6]  = '{1, 2, 0, 8'h02, 0, 0, 0, 1};
        cyc[7]  = '{0, 2, 0, 8'h02, 0, 0, 0, 1};
        cyc[8]  = '{0, 2, 1, 8'h00, 0, 0, 0, 1};
`ifdef CD_TX_CRC_EN
        cyc[9]  = '{0, 2, 1, 8'h21, 0, 0, 0, 1};
        cyc[10] = '{0, 2, 1, 8'h60, 0, 0, 0, 1};
        cyc[11] = '{0, 2, 0, 8'h60, 0, 1, 1, 1};
        cyc[12] = '{0, 2, 0, 8'h60, 0, 0, 0, 0};
        ncyc = 13;
`else
        cyc[9]  = '{0, 2, 0, 8'h00, 0, 1, 1, 1};
        cyc[10] = '{0, 2, 0, 8'h00, 0, 0, 0, 0};
        cyc[11] = '{0, 2, 0, 8'h00, 0, 0, 0, 0};
        cyc[12] = '{0, 2, 0, 8'h00, 0, 0, 0, 0};
        ncyc = 13;
`endif
        vecs[0] = '{8'h11, 8'h22, 8'd0,   100, 3};
        vecs[1] = '{8'h33, 8'h44, 8'd1,   60,  4};
        vecs[2] = '{8'h55, 8'h66, 8'd5,   50,  8};
        vecs[3] = '{8'h77, 8'h88, 8'd17,  90,  20};
        vecs[4] = '{8'h99, 8'hAA, 8'd252, 100, 255};
        vecs[5] = '{8'hBB, 8'hCC, 8'd253, 80,  256};
        vecs[6] = '{8'hDD, 8'hEE, 8'hFF,  70,  256};

        reset_n = 1'b0;
        tx_permit = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_done", int'(rd_done), 0);
        chk("rst_tx_byte", int'(tx_byte), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_fstart", int'(frame_start), 0);
        chk("rst_fend", int'(frame_end), 0);
        reset_n = 1'b1;
        tick();

        // Minimum frame, cycle by cycle.
        ready_pct = 100;
        tx_permit = 1'b1;
        clear_counts();
        load_frame(8'h01, 8'h02, 8'h00);
        for (int k = 0; k < ncyc; k++) begin
            tick();
            chk($sformatf("cyc%0d_rd_en", k), int'(rd_en), cyc[k].rd_en);
            chk($sformatf("cyc%0d_rd_addr", k), int'(rd_addr), cyc[k].rd_addr);
            chk($sformatf("cyc%0d_tx_valid", k), int'(tx_valid), cyc[k].tx_valid);
            chk($sformatf("cyc%0d_tx_byte", k), int'(tx_byte), cyc[k].tx_byte);
            chk($sformatf("cyc%0d_fstart", k), int'(frame_start), cyc[k].fstart);
            chk($sformatf("cyc%0d_fend", k), int'(frame_end), cyc[k].fend);
            chk($sformatf("cyc%0d_rd_done", k), int'(rd_done), cyc[k].rd_done);
            chk($sformatf("cyc%0d_busy", k), int'(busy), cyc[k].busy);
        end
        chk("min_dones", dones, 1);
        compare_frames("min");

        // Table vectors including the len clamp boundaries.
        for (int v = 0; v < 7; v++) begin
            clear_counts();
            ready_pct = vecs[v].ready_pct;
            load_frame(vecs[v].src, vecs[v].dst, vecs[v].len);
            wait_released(n_loaded, 6000, $sformatf("vec%0d", v));
            tick();
            chk($sformatf("vec%0d_nbytes", v), got_q.size(), vecs[v].exp_bytes + CRC_BYTES);
            chk($sformatf("vec%0d_starts", v), starts, 1);
            chk($sformatf("vec%0d_ends", v), ends, 1);
            chk($sformatf("vec%0d_dones", v), dones, 1);
            compare_frames($sformatf("vec%0d", v));
        end

        // Serializer stall on the third byte of a len=5 frame.
        clear_counts();
        ready_pct = 100;
        load_frame(8'hA5, 8'h5A, 8'd5);
        wait_got(2, 200, "hold");
        hold_ready = 1;
        wait_valid(50, "hold");
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_nacc", got_q.size(), 2);
            chk("hold_tx_byte", int'(tx_byte), int'(exp_q[2]));
        end
        chk("hold_no_done", dones, 0);
        hold_ready = 0;
        wait_released(n_loaded, 500, "hold");
        chk("hold_dones", dones, 1);
        compare_frames("hold");

        // Pending frame without grant, then grant.
        clear_counts();
        tx_permit = 1'b0;
        rd_en_cnt = 0;
        load_frame(8'h0F, 8'hF0, 8'd2);
        repeat (20) tick();
        chk("nogrant_rd_en", rd_en_cnt, 0);
        chk("nogrant_busy", int'(busy), 0);
        tx_permit = 1'b1;
        tick();
        chk("grant_rd_en", int'(rd_en), 1);
        chk("grant_busy", int'(busy), 1);
        wait_released(n_loaded, 500, "grant");
        compare_frames("grant");

        // Abort on byte 4 of a len=4 frame, then full resend.
        clear_counts();
        load_frame(8'hC1, 8'hC2, 8'd4);
        wait_got(3, 200, "abort");
        hold_ready = 1;
        wait_valid(50, "abort");
        abort = 1'b1;
        tx_permit = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_tx_valid", int'(tx_valid), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (5) tick();
        chk("abort_no_done", dones, 0);
        chk("abort_pending", int'(unread), 1);
        clear_counts();
        hold_ready = 0;
        tx_permit = 1'b1;
        wait_released(n_loaded, 500, "resend");
        chk("resend_starts", starts, 1);
        compare_frames("resend");

        // Abort coinciding with the final handshake.
        clear_counts();
        load_frame(8'hE1, 8'hE2, 8'd0);
        wait_got(2, 200, "abort_last");
        hold_ready = 1;
        wait_valid(50, "abort_last");
        abort = 1'b1;
        tx_permit = 1'b0;
        hold_ready = 0;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        chk("abort_last_ends", ends, 0);
        chk("abort_last_dones", dones, 0);
        chk("abort_last_pending", int'(unread), 1);
        clear_counts();
        tx_permit = 1'b1;
        wait_released(n_loaded, 500, "abort_last_resend");
        chk("abort_last_resend_ends", ends, 1);
        compare_frames("abort_last_resend");

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("idle_abort_busy", int'(busy), 0);

        // Two pending buffers.
        clear_counts();
        ready_pct = 75;
        load_frame(8'h21, 8'h12, 8'd6);
        load_frame(8'h43, 8'h34, 8'd3);
        wait_released(n_loaded, 1000, "b2b");
        chk("b2b_dones", dones, 2);
        chk("b2b_starts", starts, 2);
        chk("b2b_gap_idle", int'(gap_idle), 1);
        compare_frames("b2b");

        // Reset mid-SEND.
        clear_counts();
        ready_pct = 100;
        load_frame(8'h5C, 8'hC5, 8'd5);
        wait_got(2, 200, "rst");
        hold_ready = 1;
        wait_valid(50, "rst");
        tx_permit = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_tx_valid", int'(tx_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_tx_byte", int'(tx_byte), 0);
        chk("rst_mid_rd_addr", int'(rd_addr), 0);
        chk("rst_mid_rd_done", int'(rd_done), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_mid_no_done", dones, 0);
        chk("rst_mid_pending", int'(unread), 1);
        clear_counts();
        hold_ready = 0;
        tx_permit = 1'b1;
        wait_released(n_loaded, 500, "rst_resend");
        compare_frames("rst_resend");

        // Randomized frames against the model.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] len;
            clear_counts();
            ready_pct = int'($urandom_range(30, 100));
            len = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 24));
            load_frame(8'($urandom), 8'($urandom), len);
            if ($urandom_range(0, 2) == 0)
                load_frame(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)));
            wait_released(n_loaded, 8000, $sformatf("rnd%0d", r));
            tick();
            chk($sformatf("rnd%0d_starts", r), starts, dones);
            chk($sformatf("rnd%0d_ends", r), ends, dones);
            compare_frames($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
